bus2_line_master: RTL and testbench
===================================

BUS2_LINE_MASTER -- requirements
Module: bus2_line_master

Interface
REQ-001 Parameter ADDR2_BUS_SIZE, default 15, line address width (byte address >> CACHE_OFFSET_SIZE).
REQ-002 Parameter DATA_BUS_SIZE, default 16, bus2 data width; one beat = 2 bytes.
REQ-003 Parameter CTR2_BUS_SIZE, default 2, bus2 command width.
REQ-004 Parameter CACHE_LINE_SIZE, default 16, line size in bytes; BEATS = CACHE_LINE_SIZE/2 = 8.
REQ-005 Parameter TIMEOUT_CYCLES, default 200, maximum wait for C2_RESPONSE.
REQ-006 Fixed encodings: C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3.
REQ-007 CLK  in  1  single clock; all logic on posedge.
REQ-008 RESET_N  in  1  asynchronous, active-low reset.
REQ-009 req_valid  in  1  cache requests a line transfer.
REQ-010 req_ready  out  1  block accepts a request this cycle.
REQ-011 req_write  in  1  1 = write line, 0 = read line.
REQ-012 req_addr  in  ADDR2_BUS_SIZE  line address.
REQ-013 req_wdata  in  8*CACHE_LINE_SIZE  write line; byte i = bits [8i+7:8i].
REQ-014 rsp_valid  out  1  one-cycle completion pulse.
REQ-015 rsp_err  out  1  qualifies rsp_valid; 1 = timeout.
REQ-016 rsp_rdata  out  8*CACHE_LINE_SIZE  read line, same byte order as req_wdata.
REQ-017 a2_out/a2_oe  out  ADDR2_BUS_SIZE/1  A2 drive value and enable.
REQ-018 d2_out/d2_oe  out  DATA_BUS_SIZE/1  D2 drive value and enable; d2_in  in  DATA_BUS_SIZE  D2 sampled value.
REQ-019 c2_out/c2_oe  out  CTR2_BUS_SIZE/1  C2 drive value and enable; c2_in  in  CTR2_BUS_SIZE  C2 sampled value.

Function
REQ-020 States: IDLE, CMD, WR_BEAT, WAIT_RSP, RD_BEAT, DONE.
REQ-021 req_ready=1 only in IDLE; handshake = req_valid & req_ready; addr, write flag, wdata latched on handshake; IDLE -> CMD.
REQ-022 CMD (1 cycle): a2_oe=c2_oe=1, a2_out=latched addr, c2_out=READ_LINE or WRITE_LINE.
REQ-023 CMD write: also d2_oe=1, d2_out={byte1,byte0} (little-endian: D2[7:0]=lower byte); CMD -> WR_BEAT; CMD read -> WAIT_RSP.
REQ-024 WR_BEAT: 7 cycles, beat k (1..7) drives {byte 2k+1, byte 2k}, c2_out=NOP, c2_oe=d2_oe=1, a2_oe=0; after beat 7 -> WAIT_RSP.
REQ-025 WAIT_RSP: all oe=0; timeout counter cleared on entry, +1 per cycle.
REQ-026 WAIT_RSP, c2_in==RESPONSE, read: d2_in captured as beat 0 that same cycle -> RD_BEAT; write -> DONE, rsp_err=0.
REQ-027 RD_BEAT: capture d2_in as beats 1..7 on 7 consecutive cycles, c2_in ignored; after beat 7 -> DONE, rsp_err=0.
REQ-028 Counter reaches TIMEOUT_CYCLES with no RESPONSE -> DONE, rsp_err=1; rsp_rdata contents then undefined.
REQ-029 DONE (1 cycle): rsp_valid=1, rsp_rdata stable until next read completes; -> IDLE.
REQ-030 Read latency: C2_RESPONSE cycle + 8 cycles to rsp_valid; write: RESPONSE cycle + 1.
REQ-031 c2_in values other than RESPONSE during WAIT_RSP are ignored; no oe ever asserted outside CMD/WR_BEAT.
REQ-032 req_valid during non-IDLE states is ignored (req_ready=0); no request queuing.

Reset
REQ-033 RESET_N=0 immediately: state=IDLE, all oe=0, a2_out=d2_out=0, c2_out=NOP, rsp_valid=rsp_err=0, rsp_rdata=0, counter=0; mid-transfer aborted, no rsp_valid.

Verification
REQ-034 Read addr 0x0005, model answers RESPONSE 100 cycles after CMD with beats 0x0100,0x0302..0x0F0E -> rsp_valid 8 cycles later, rsp_rdata bytes 0..15 = 0x00..0x0F, rsp_err=0.
REQ-035 Write addr 0x1234, wdata bytes 0xA0..0xAF -> CMD drives C2=3, A2=0x1234, D2=0xA1A0; next 7 cycles D2=0xA3A2..0xAFAE, C2=NOP; oe drop; RESPONSE -> rsp_valid next cycle.
REQ-036 Read with no RESPONSE -> rsp_valid, rsp_err=1 exactly TIMEOUT_CYCLES cycles after WAIT_RSP entry.
REQ-037 RESET_N pulsed low during WR_BEAT beat 3 -> all oe=0 asynchronously, req_ready=1 after release, no rsp_valid.
REQ-038 req_valid held high continuously -> req_ready=1 only in IDLE; two back-to-back reads complete in order, each one rsp_valid.

Source files
------------

// File: rtl/bus2_line_master.sv
// bus2_line_master
//   Moves one cache line between a cache-side request port and the shared
//   bus2 (A2/D2/C2). A line is 8 beats of 2 bytes; beat k carries bytes
//   {2k+1, 2k} with the lower byte on D2[7:0]. Writes put the command and
//   beat 0 on the bus together, then beats 1..7, and wait for C2_RESPONSE.
//   Reads put the command out, wait for C2_RESPONSE (which carries beat 0),
//   then sample beats 1..7. A missing response times out with rsp_err=1.
//
// Ports
//   CLK, RESET_N              clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake (ready only while idle)
//   req_write/addr/wdata      request attributes, latched at handshake
//   rsp_valid/rsp_err         one-cycle completion pulse, err = timeout
//   rsp_rdata                 last read line, held until the next read completes
//   a2_*/d2_*/c2_*            bus2 drive values, output enables and sampled inputs
module bus2_line_master #(
    parameter int ADDR2_BUS_SIZE  = 15,
    parameter int DATA_BUS_SIZE   = 16,
    parameter int CTR2_BUS_SIZE   = 2,
    parameter int CACHE_LINE_SIZE = 16,
    parameter int TIMEOUT_CYCLES  = 200
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR2_BUS_SIZE-1:0]    req_addr,
    input  logic [8*CACHE_LINE_SIZE-1:0] req_wdata,
    output logic                         rsp_valid,
    output logic                         rsp_err,
    output logic [8*CACHE_LINE_SIZE-1:0] rsp_rdata,
    output logic [ADDR2_BUS_SIZE-1:0]    a2_out,
    output logic                         a2_oe,
    output logic [DATA_BUS_SIZE-1:0]     d2_out,
    output logic                         d2_oe,
    input  logic [DATA_BUS_SIZE-1:0]     d2_in,
    output logic [CTR2_BUS_SIZE-1:0]     c2_out,
    output logic                         c2_oe,
    input  logic [CTR2_BUS_SIZE-1:0]     c2_in
);

    localparam int LINE_W = 8 * CACHE_LINE_SIZE;
    localparam int BEATS  = LINE_W / DATA_BUS_SIZE;
    localparam int REST_W = LINE_W - DATA_BUS_SIZE;   // beats 1..BEATS-1
    localparam int BCW    = $clog2(BEATS);
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = CTR2_BUS_SIZE'(0);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR_BEAT,
        S_WAIT_RSP,
        S_RD_BEAT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_write;
    logic [REST_W-1:0]   r_wdata;   // beats still to be sent, next one in the low bits
    logic [REST_W-1:0]   r_line;    // read beats collected so far, newest on top
    logic [BCW-1:0]      r_beat;
    logic [TW-1:0]       r_tmo;

    assign req_ready = (r_state == S_IDLE);

    // All bus and response outputs are registered: each is loaded on the
    // edge that enters the state in which it must be visible.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_line    <= '0;
            r_beat    <= '0;
            r_tmo     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            a2_out    <= '0;
            a2_oe     <= 1'b0;
            d2_out    <= '0;
            d2_oe     <= 1'b0;
            c2_out    <= C2_NOP;
            c2_oe     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_wdata <= req_wdata[LINE_W-1:DATA_BUS_SIZE];
                        a2_out  <= req_addr;
                        a2_oe   <= 1'b1;
                        c2_oe   <= 1'b1;
                        c2_out  <= req_write ? C2_WRITE_LINE : C2_READ_LINE;
                        if (req_write) begin
                            d2_out <= req_wdata[DATA_BUS_SIZE-1:0];
                            d2_oe  <= 1'b1;
                        end
                        r_state <= S_CMD;
                    end
                end

                S_CMD: begin
                    a2_oe  <= 1'b0;
                    c2_out <= C2_NOP;
                    if (r_write) begin
                        // C2 and D2 stay driven through the data beats
                        d2_out  <= r_wdata[DATA_BUS_SIZE-1:0];
                        r_wdata <= {{DATA_BUS_SIZE{1'b0}}, r_wdata[REST_W-1:DATA_BUS_SIZE]};
                        r_beat  <= BCW'(1);
                        r_state <= S_WR_BEAT;
                    end else begin
                        c2_oe   <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= S_WAIT_RSP;
                    end
                end

                S_WR_BEAT: begin
                    if (r_beat == BCW'(BEATS - 1)) begin
                        c2_oe   <= 1'b0;
                        d2_oe   <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= S_WAIT_RSP;
                    end else begin
                        d2_out  <= r_wdata[DATA_BUS_SIZE-1:0];
                        r_wdata <= {{DATA_BUS_SIZE{1'b0}}, r_wdata[REST_W-1:DATA_BUS_SIZE]};
                        r_beat  <= r_beat + BCW'(1);
                    end
                end

                S_WAIT_RSP: begin
                    r_tmo <= r_tmo + TW'(1);
                    if (c2_in == C2_RESPONSE) begin
                        if (r_write) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            r_state   <= S_DONE;
                        end else begin
                            // the response cycle already carries beat 0
                            r_line  <= {d2_in, r_line[REST_W-1:DATA_BUS_SIZE]};
                            r_beat  <= BCW'(1);
                            r_state <= S_RD_BEAT;
                        end
                    end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        // counter reaches TIMEOUT_CYCLES on this edge
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end

                S_RD_BEAT: begin
                    if (r_beat == BCW'(BEATS - 1)) begin
                        // publish the whole line at once so rsp_rdata only
                        // changes when a read completes
                        rsp_rdata <= {d2_in, r_line};
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_line <= {d2_in, r_line[REST_W-1:DATA_BUS_SIZE]};
                        r_beat <= r_beat + BCW'(1);
                    end
                end

                S_DONE: begin
                    rsp_err <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus2_line_master.sv
// Directed + randomized bench for bus2_line_master. A behavioural bus model
// lives in run_txn: it knows what the bus must show on each cycle of a
// transaction, plays the slave side (response after a chosen delay, read
// beats, junk on C2/D2 where it must be ignored) and predicts rsp_* from the
// byte-level line contents.
module tb_bus2_line_master;

    localparam int T = 200;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          req_valid, req_ready, req_write;
    logic [14:0]   req_addr;
    logic [127:0]  req_wdata;
    logic          rsp_valid, rsp_err;
    logic [127:0]  rsp_rdata;
    logic [14:0]   a2_out;
    logic          a2_oe;
    logic [15:0]   d2_out, d2_in;
    logic          d2_oe;
    logic [1:0]    c2_out, c2_in;
    logic          c2_oe;

    int n_assert = 0;
    int n_fail   = 0;

    logic [127:0]  last_rd;
    bit            rd_known;

    bus2_line_master #(
        .ADDR2_BUS_SIZE(15), .DATA_BUS_SIZE(16), .CTR2_BUS_SIZE(2),
        .CACHE_LINE_SIZE(16), .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .a2_out(a2_out), .a2_oe(a2_oe),
        .d2_out(d2_out), .d2_oe(d2_oe), .d2_in(d2_in),
        .c2_out(c2_out), .c2_oe(c2_oe), .c2_in(c2_in)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // outputs are sampled and inputs driven on the falling edge
    task automatic step();
        @(negedge CLK);
    endtask

    function automatic logic [15:0] beat_of(input logic [127:0] line, input int k);
        logic [7:0] lo, hi;
        lo = line[16*k +: 8];       // byte 2k -> D2[7:0]
        hi = line[16*k + 8 +: 8];   // byte 2k+1 -> D2[15:8]
        return {hi, lo};
    endfunction

    function automatic logic [1:0] junk_c2();
        int v;
        v = $urandom_range(0, 2);
        return (v == 0) ? 2'd0 : 2'(v + 1);   // anything but RESPONSE
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full transaction, entered and left on an idle-cycle falling edge.
    // dly: WAIT_RSP cycle (0 = first) in which RESPONSE appears; dly >= T
    // means no response at all.
    task automatic run_txn(input bit wr, input logic [14:0] addr,
                           input logic [127:0] wdata, input int dly,
                           input logic [127:0] rline, input bit hold);
        chk("idle_ready", req_ready, 1'b1);
        chk("idle_valid", rsp_valid, 1'b0);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        c2_in     = junk_c2();

        step();  // command cycle
        if (!hold) req_valid = 1'b0;
        req_addr  = 15'($urandom);   // must already be latched
        req_wdata = rand_line();
        chk("cmd_oe", {a2_oe, c2_oe, d2_oe}, {2'b11, wr});
        chk("cmd_a2", a2_out, addr);
        chk("cmd_c2", c2_out, wr ? 2'd3 : 2'd2);
        chk("cmd_ready", req_ready, 1'b0);
        if (wr) chk("cmd_d2", d2_out, beat_of(wdata, 0));

        if (wr) begin
            for (int k = 1; k < 8; k++) begin
                step();
                chk("wr_oe", {a2_oe, c2_oe, d2_oe}, 3'b011);
                chk("wr_c2", c2_out, 2'd0);
                chk("wr_d2", d2_out, beat_of(wdata, k));
                chk("wr_ready", req_ready, 1'b0);
            end
        end

        for (int w = 0; w <= T; w++) begin
            step();
            if (w == T) begin
                chk("tmo_valid", rsp_valid, 1'b1);
                chk("tmo_err", rsp_err, 1'b1);
                rd_known = 1'b0;
                break;
            end
            chk("wait_oe", {a2_oe, c2_oe, d2_oe}, 3'b000);
            chk("wait_valid", rsp_valid, 1'b0);
            chk("wait_ready", req_ready, 1'b0);
            if (w == dly) begin
                c2_in = 2'd1;
                d2_in = wr ? 16'($urandom) : beat_of(rline, 0);
                break;
            end
            c2_in = junk_c2();
            d2_in = 16'($urandom);
        end

        if (dly < T) begin
            if (!wr) begin
                for (int k = 1; k < 8; k++) begin
                    step();
                    chk("rd_oe", {a2_oe, c2_oe, d2_oe}, 3'b000);
                    chk("rd_valid", rsp_valid, 1'b0);
                    d2_in = beat_of(rline, k);
                    c2_in = 2'($urandom);    // ignored during the beats
                end
            end
            step();
            chk("done_valid", rsp_valid, 1'b1);
            chk("done_err", rsp_err, 1'b0);
            if (!wr) begin
                chk("done_rdata", rsp_rdata, rline);
                last_rd  = rline;
                rd_known = 1'b1;
            end else if (rd_known) begin
                chk("wr_rdata_held", rsp_rdata, last_rd);
            end
        end
        c2_in = 2'd0;
        d2_in = 16'($urandom);

        step();  // back in idle
        chk("post_valid", rsp_valid, 1'b0);
        chk("post_ready", req_ready, 1'b1);
        chk("post_oe", {a2_oe, c2_oe, d2_oe}, 3'b000);
        if (rd_known) chk("post_rdata", rsp_rdata, last_rd);
    endtask

    initial begin
        logic [127:0] ln, wd;
        RESET_N   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        c2_in     = 2'd0;
        d2_in     = '0;
        last_rd   = '0;
        rd_known  = 1'b1;

        #3;
        chk("rst_oe", {a2_oe, c2_oe, d2_oe}, 3'b000);
        chk("rst_bus", {a2_out, d2_out, c2_out}, '0);
        chk("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
        chk("rst_rdata", rsp_rdata, '0);
        chk("rst_ready", req_ready, 1'b1);
        step();
        RESET_N = 1'b1;

        // read of line 5, response 100 cycles after the command, bytes 0x00..0x0F
        for (int i = 0; i < 16; i++) ln[8*i +: 8] = 8'(i);
        run_txn(1'b0, 15'h0005, '0, 99, ln, 1'b0);

        // write of line 0x1234, bytes 0xA0..0xAF
        for (int i = 0; i < 16; i++) wd[8*i +: 8] = 8'(8'hA0 + i);
        run_txn(1'b1, 15'h1234, wd, 3, '0, 1'b0);

        // read with no response at all
        run_txn(1'b0, 15'h0777, '0, T, '0, 1'b0);

        // response in the very first wait cycle
        run_txn(1'b0, 15'h7FFF, '0, 0, rand_line(), 1'b0);

        // req_valid held high: two reads back to back, each completes once
        run_txn(1'b0, 15'h0101, '0, 2, rand_line(), 1'b1);
        run_txn(1'b0, 15'h0202, '0, 5, rand_line(), 1'b1);
        req_valid = 1'b0;

        // reset in the middle of write beat 3
        wd = rand_line();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 15'h0333;
        req_wdata = wd;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        chk("pre_rst_d2", d2_out, beat_of(wd, 3));
        #1 RESET_N = 1'b0;
        #1;
        chk("arst_oe", {a2_oe, c2_oe, d2_oe}, 3'b000);
        chk("arst_bus", {a2_out, d2_out, c2_out}, '0);
        chk("arst_rsp", {rsp_valid, rsp_err}, 2'b00);
        chk("arst_rdata", rsp_rdata, '0);
        chk("arst_ready", req_ready, 1'b1);
        last_rd  = '0;
        rd_known = 1'b1;
        step();
        RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rel_valid", rsp_valid, 1'b0);
            chk("rel_ready", req_ready, 1'b1);
            chk("rel_oe", {a2_oe, c2_oe, d2_oe}, 3'b000);
        end

        // randomized traffic
        for (int n = 0; n < 14; n++) begin
            bit wr;
            int dly;
            wr  = 1'($urandom);
            dly = ($urandom_range(0, 7) == 0) ? T : int'($urandom_range(0, 40));
            run_txn(wr, 15'($urandom), rand_line(), dly, rand_line(), 1'($urandom));
            req_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
